// File: rtl/logger_pkg.sv
// Shared definitions for the trigger-based capture controller.
package logger_pkg;

   // Controller states: capture phases, then two-step readout, then done.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FILL     = 3'd1,
      ARMED    = 3'd2,
      POST     = 3'd3,
      RD_FETCH = 3'd4,
      RD_SHOW  = 3'd5,
      DONE     = 3'd6
   } logger_state_t;

   // Buffer depth in words for a given RAM address width.
   function automatic int logger_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/logger_capture_ctrl.sv
// Logic-analyser style capture controller driving an external dual-port RAM
// as a circular buffer: pre-trigger history, trigger sample, post-trigger
// samples (DEPTH words total), then oldest-first readout over valid/ready.
module logger_capture_ctrl
   import logger_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          arm,
   input  logic          abort,
   input  logic [AW-1:0] pretrig_len,
   input  logic [DW-1:0] sample,
   input  logic          sample_valid,
   input  logic          trigger,
   output logic          ram_wr_en,
   output logic [AW-1:0] ram_addr_w,
   output logic [DW-1:0] ram_data_in,
   output logic [AW-1:0] ram_addr_r,
   input  logic [DW-1:0] ram_data_out,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          triggered,
   output logic          done
);

   localparam int            DEPTH    = logger_depth(AW);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE      = AW'(1);

   // Registered state
   logger_state_t r_state;
   logic [AW-1:0] r_wr_ptr;     // next RAM write address
   logic [AW-1:0] r_rd_ptr;     // RAM read address, held during a stall
   logic [AW-1:0] r_cnt;        // history samples written while in FILL
   logic [AW-1:0] r_plen;       // latched pre-trigger length
   logic [AW-1:0] r_post;       // post-trigger samples still to write
   logic [AW-1:0] r_rcnt;       // words already handed downstream
   logic          r_triggered;
   logic          r_done;

   // Next-state values
   logger_state_t w_state_next;
   logic [AW-1:0] w_wr_ptr_next;
   logic [AW-1:0] w_rd_ptr_next;
   logic [AW-1:0] w_cnt_next;
   logic [AW-1:0] w_plen_next;
   logic [AW-1:0] w_post_next;
   logic [AW-1:0] w_rcnt_next;
   logic          w_triggered_next;
   logic          w_done_next;

   // Helpers
   logic          w_wr_en;
   logic          w_capturing;
   logic [AW-1:0] w_plen_clamped;
   logic [AW-1:0] w_cnt_inc;
   logic [AW-1:0] w_wr_ptr_inc;
   logic [AW-1:0] w_post_load;
   logic          w_accept;

   // Capture phases are the only states in which the RAM write port is active.
   assign w_capturing    = (r_state == FILL) || (r_state == ARMED) || (r_state == POST);
   // Out-of-range pre-trigger lengths saturate at the largest legal value.
   assign w_plen_clamped = (pretrig_len > LAST_IDX) ? LAST_IDX : pretrig_len;
   assign w_cnt_inc      = r_cnt + ONE;
   assign w_wr_ptr_inc   = r_wr_ptr + ONE;
   assign w_post_load    = LAST_IDX - r_plen;
   assign w_accept       = (r_state == RD_SHOW) && out_ready;

   // Next-state and datapath update logic for the capture/readout sequencer.
   always_comb begin
      w_state_next     = r_state;
      w_wr_ptr_next    = r_wr_ptr;
      w_rd_ptr_next    = r_rd_ptr;
      w_cnt_next       = r_cnt;
      w_plen_next      = r_plen;
      w_post_next      = r_post;
      w_rcnt_next      = r_rcnt;
      w_triggered_next = r_triggered;
      w_done_next      = r_done;
      w_wr_en          = w_capturing && sample_valid;

      case (r_state)
         IDLE, DONE: begin
            if (arm) begin
               // The write pointer keeps running; any start address works
               // because the window is located relative to the final pointer.
               w_state_next     = FILL;
               w_plen_next      = w_plen_clamped;
               w_cnt_next       = '0;
               w_triggered_next = 1'b0;
               w_done_next      = 1'b0;
            end
         end

         FILL: begin
            // Triggers are ignored until enough history has been collected.
            if (r_plen == '0) begin
               w_state_next = ARMED;
            end else if (sample_valid) begin
               w_cnt_next = w_cnt_inc;
               if (w_cnt_inc == r_plen) begin
                  w_state_next = ARMED;
               end
            end
         end

         ARMED: begin
            if (sample_valid && trigger) begin
               w_triggered_next = 1'b1;
               if (w_post_load == '0) begin
                  // Trigger sample is the newest word of the window.
                  w_state_next  = RD_FETCH;
                  w_rd_ptr_next = w_wr_ptr_inc;
                  w_rcnt_next   = '0;
               end else begin
                  w_state_next = POST;
                  w_post_next  = w_post_load;
               end
            end
         end

         POST: begin
            if (sample_valid) begin
               w_post_next = r_post - ONE;
               if (r_post == ONE) begin
                  // Oldest word now sits at the post-increment write pointer.
                  w_state_next  = RD_FETCH;
                  w_rd_ptr_next = w_wr_ptr_inc;
                  w_rcnt_next   = '0;
               end
            end
         end

         RD_FETCH: begin
            // RAM registers the read this cycle; data is valid next cycle.
            w_state_next = RD_SHOW;
         end

         RD_SHOW: begin
            if (w_accept) begin
               if (r_rcnt == LAST_IDX) begin
                  w_state_next = DONE;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next  = RD_FETCH;
                  w_rcnt_next   = r_rcnt + ONE;
                  w_rd_ptr_next = r_rd_ptr + ONE;
               end
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase

      // Abort dominates arm and trigger and suppresses this cycle's write.
      if (abort) begin
         w_state_next     = IDLE;
         w_triggered_next = 1'b0;
         w_done_next      = 1'b0;
         w_wr_en          = 1'b0;
      end

      if (w_wr_en) begin
         w_wr_ptr_next = w_wr_ptr_inc;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_plen      <= '0;
         r_post      <= '0;
         r_rcnt      <= '0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_wr_ptr    <= w_wr_ptr_next;
         r_rd_ptr    <= w_rd_ptr_next;
         r_cnt       <= w_cnt_next;
         r_plen      <= w_plen_next;
         r_post      <= w_post_next;
         r_rcnt      <= w_rcnt_next;
         r_triggered <= w_triggered_next;
         r_done      <= w_done_next;
      end
   end

   // RAM write port follows the current state and live sample inputs.
   assign ram_wr_en   = w_wr_en;
   assign ram_addr_w  = r_wr_ptr;
   assign ram_data_in = sample;
   assign ram_addr_r  = r_rd_ptr;

   // Readout: read address is held in RD_SHOW, so the RAM output is stable.
   assign out_valid = (r_state == RD_SHOW);
   assign out_data  = (r_state == RD_SHOW) ? ram_data_out : '0;
   assign out_last  = (r_state == RD_SHOW) && (r_rcnt == LAST_IDX);

   // Status
   assign busy      = (r_state != IDLE) && (r_state != DONE);
   assign triggered = r_triggered;
   assign done      = r_done;

endmodule

// File: tb/tb_logger_capture_ctrl.sv
// Self-checking bench for logger_capture_ctrl with a behavioural RAM and a
// window reference model derived from the capture rules.
module tb_logger_capture_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int NCYC  = 200;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] pretrig_len = '0;
   logic [DW-1:0] sample = '0;
   logic          sample_valid = 1'b0;
   logic          trigger = 1'b0;
   logic          out_ready = 1'b0;
   logic          ram_wr_en;
   logic [AW-1:0] ram_addr_w;
   logic [DW-1:0] ram_data_in;
   logic [AW-1:0] ram_addr_r;
   logic [DW-1:0] ram_data_out = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          busy;
   logic          triggered;
   logic          done;

   int tests = 0;
   int fails = 0;

   // Stimulus stream (per cycle after arm) and model results
   logic [DW-1:0] s_val [NCYC];
   logic          s_vld [NCYC];
   logic          s_trg [NCYC];
   logic [DW-1:0] exp_q [$];
   int            t_cyc;
   int            l_cyc;

   logger_capture_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arm          (arm),
      .abort        (abort),
      .pretrig_len  (pretrig_len),
      .sample       (sample),
      .sample_valid (sample_valid),
      .trigger      (trigger),
      .ram_wr_en    (ram_wr_en),
      .ram_addr_w   (ram_addr_w),
      .ram_data_in  (ram_data_in),
      .ram_addr_r   (ram_addr_r),
      .ram_data_out (ram_data_out),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .busy         (busy),
      .triggered    (triggered),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Dual-port RAM: synchronous write, registered read.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr_w] <= ram_data_in;
      ram_data_out <= mem[ram_addr_r];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Window model: list valid samples in arrival order; the trigger is the
   // first flagged sample with at least plen samples before it; the window is
   // plen samples before it through DEPTH-1-plen after it.
   task automatic model_window(input int plen);
      logic [DW-1:0] v [$];
      int            cyc_of [$];
      int            t;
      exp_q.delete();
      t = -1;
      t_cyc = -1;
      l_cyc = -1;
      for (int i = 1; i < NCYC; i++) begin
         if (s_vld[i]) begin
            if (t < 0 && v.size() >= plen && s_trg[i]) begin
               t = v.size();
               t_cyc = i;
            end
            v.push_back(s_val[i]);
            cyc_of.push_back(i);
         end
      end
      if (t >= 0 && (t - plen + DEPTH) <= v.size()) begin
         for (int j = 0; j < DEPTH; j++) exp_q.push_back(v[t - plen + j]);
         l_cyc = cyc_of[t - plen + DEPTH - 1];
      end
   endtask

   // Incrementing stream, every cycle valid except the first after arm.
   task automatic fill_incr(input int base, input int ta, input int tb);
      for (int i = 0; i < NCYC; i++) begin
         s_vld[i] = (i > 0);
         s_val[i] = DW'(base + i - 1);
         s_trg[i] = (i > 0) && ((int'(s_val[i]) == ta) || (int'(s_val[i]) == tb));
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NCYC; i++) begin
         s_vld[i] = (i == 0) ? 1'b0 : ((i >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0));
         s_val[i] = DW'($urandom);
         s_trg[i] = (i == 50) ? 1'b1 : ($urandom_range(0, 7) == 0);
      end
   endtask

   task automatic arm_capture(input int plen);
      pretrig_len  = AW'(plen);
      arm          = 1'b1;
      sample_valid = 1'b0;
      trigger      = 1'b0;
      tick();
      arm = 1'b0;
      tests++;
      if (busy !== 1'b1 || triggered !== 1'b0 || done !== 1'b0)
         $display("FAIL arm_start: busy=%0b trig=%0b done=%0b, need 1/0/0", busy, triggered, done);
      if (busy !== 1'b1 || triggered !== 1'b0 || done !== 1'b0) fails++;
   endtask

   task automatic drive_capture(input int upto, input bit rand_arm);
      for (int i = 0; i <= upto; i++) begin
         sample       = s_val[i];
         sample_valid = (i == 0) ? 1'b0 : s_vld[i];
         trigger      = s_trg[i];
         arm          = rand_arm ? ($urandom_range(0, 3) == 0) : 1'b0;
         #1;
         tests++;
         if (ram_wr_en !== sample_valid) begin
            fails++;
            $display("FAIL wr_en cyc %0d: got %0b need %0b", i, ram_wr_en, sample_valid);
         end
         tick();
         tests++;
         if (triggered !== (t_cyc >= 0 && i >= t_cyc)) begin
            fails++;
            $display("FAIL triggered cyc %0d: got %0b need %0b", i, triggered, (t_cyc >= 0 && i >= t_cyc));
         end
      end
      sample_valid = 1'b0;
      trigger      = 1'b0;
      arm          = 1'b0;
   endtask

   // mode 0: ready always high; 1: 1-0-0-1 pattern; 2: random.
   task automatic read_out(input int mode, input int n_stop);
      int            n;
      int            cyc;
      bit            prev_stall;
      bit            rdy;
      logic [DW-1:0] held_data;
      logic          held_last;
      n = 0;
      cyc = 0;
      prev_stall = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      while (n < n_stop && cyc < 20 * DEPTH) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
               fails++;
               $display("FAIL stall_hold: valid=%0b data=%02h last=%0b, need 1/%02h/%0b",
                        out_valid, out_data, out_last, held_data, held_last);
            end
         end
         prev_stall = 1'b0;
         if (out_valid === 1'b1) begin
            if (rdy) begin
               tests++;
               if (out_data !== exp_q[n] || out_last !== (n == DEPTH - 1)) begin
                  fails++;
                  $display("FAIL word %0d: data=%02h last=%0b, need %02h/%0b",
                           n, out_data, out_last, exp_q[n], (n == DEPTH - 1));
               end
               n++;
            end else begin
               prev_stall = 1'b1;
               held_data  = out_data;
               held_last  = out_last;
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      tests++;
      if (n != n_stop) begin
         fails++;
         $display("FAIL readout_timeout: got %0d words, need %0d", n, n_stop);
      end
      if (n_stop == DEPTH) begin
         if (mode == 0) begin
            tests++;
            if (cyc != 2 * DEPTH) begin
               fails++;
               $display("FAIL throughput: %0d cycles, need %0d", cyc, 2 * DEPTH);
            end
         end
         tests++;
         if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || triggered !== 1'b1) begin
            fails++;
            $display("FAIL end_status: done=%0b busy=%0b valid=%0b trig=%0b, need 1/0/0/1",
                     done, busy, out_valid, triggered);
         end
         tick();
         tick();
         tests++;
         if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_hold: got %0b need 1", done);
         end
      end
   endtask

   task automatic run_capture(input int plen, input int mode);
      model_window(plen);
      tests++;
      if (l_cyc < 0) begin
         fails++;
         $display("FAIL stimulus: no complete window for plen %0d", plen);
         return;
      end
      arm_capture(plen);
      drive_capture(l_cyc, 1'b1);
      // Last window write has landed: RD_FETCH now, RD_SHOW next.
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL fetch_entry: busy=%0b valid=%0b, need 1/0", busy, out_valid);
      end
      read_out(mode, DEPTH);
      $display("[TB] capture plen=%0d mode=%0d trig_cyc=%0d first=%02h last=%02h",
               plen, mode, t_cyc, exp_q[0], exp_q[DEPTH - 1]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sample_valid = 1'b1;
      tick();
      tick();
      tests++;
      if (busy !== 0 || done !== 0 || triggered !== 0 || out_valid !== 0 || out_last !== 0) begin
         fails++;
         $display("FAIL reset_status: busy=%0b done=%0b trig=%0b valid=%0b last=%0b, need 0",
                  busy, done, triggered, out_valid, out_last);
      end
      tests++;
      if (ram_wr_en !== 0 || ram_addr_w !== '0 || ram_addr_r !== '0 || out_data !== '0) begin
         fails++;
         $display("FAIL reset_ram: wr_en=%0b aw=%0h ar=%0h data=%02h, need 0",
                  ram_wr_en, ram_addr_w, ram_addr_r, out_data);
      end
      rst_n = 1'b1;
      sample_valid = 1'b0;
      tick();
      $display("[TB] reset checked");
   endtask

   task automatic test_basic();
      fill_incr(0, 9, -1);
      run_capture(4, 0);
   endtask

   task automatic test_plen0();
      fill_incr(8'h30, 8'h30, -1);
      run_capture(0, 0);
   endtask

   task automatic test_plen15();
      fill_incr(0, 19, -1);
      run_capture(15, 0);
   endtask

   task automatic test_fill_trigger();
      fill_incr(0, 1, 7);
      run_capture(4, 0);
   endtask

   task automatic test_stall();
      fill_incr(8'hA0, 8'hA8, -1);
      run_capture(5, 1);
   endtask

   task automatic test_abort_reset();
      fill_incr(8'h50, 8'h55, -1);
      model_window(2);
      arm_capture(2);
      drive_capture(t_cyc + 3, 1'b0);
      tests++;
      if (busy !== 1'b1 || triggered !== 1'b1) begin
         fails++;
         $display("FAIL pre_abort: busy=%0b trig=%0b, need 1/1", busy, triggered);
      end
      abort = 1'b1;
      arm = 1'b1;
      sample_valid = 1'b1;
      trigger = 1'b1;
      sample = 8'hEE;
      #1;
      tests++;
      if (ram_wr_en !== 1'b0) begin
         fails++;
         $display("FAIL abort_wr_en: got %0b need 0", ram_wr_en);
      end
      tick();
      abort = 1'b0;
      arm = 1'b0;
      sample_valid = 1'b0;
      trigger = 1'b0;
      tick();
      tests++;
      if (busy !== 0 || triggered !== 0 || out_valid !== 0 || done !== 0) begin
         fails++;
         $display("FAIL after_abort: busy=%0b trig=%0b valid=%0b done=%0b, need 0",
                  busy, triggered, out_valid, done);
      end
      $display("[TB] abort in POST checked");

      fill_incr(8'h60, 8'h68, -1);
      model_window(3);
      arm_capture(3);
      drive_capture(l_cyc, 1'b0);
      read_out(2, 5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++;
      if (busy !== 0 || out_valid !== 0 || done !== 0 || triggered !== 0) begin
         fails++;
         $display("FAIL mid_read_reset: busy=%0b valid=%0b done=%0b trig=%0b, need 0",
                  busy, out_valid, done, triggered);
      end
      $display("[TB] reset during readout checked");

      fill_incr(8'h70, 8'h7A, -1);
      run_capture(6, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         fill_random();
         run_capture(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_plen0();
      test_plen15();
      test_fill_trigger();
      test_stall();
      test_abort_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
